// File: rtl/panel_input_conditioner_pkg.sv
// Shared definitions for the panel input conditioner: controller state
// encoding, credit limits and default parameter values.
package panel_input_conditioner_pkg;

  localparam int unsigned STATE_W                 = 3;
  localparam int unsigned CREDIT_W                = 4;
  localparam int unsigned DEB_CNT_W               = 4;
  localparam int unsigned CREDIT_MAX              = 15;
  localparam int unsigned COIN_PRICE_DEFAULT      = 3;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 4;

  // Controller state encoding; ST_IDLE must stay at zero.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_WASH  = 3'd2,
    ST_RINSE = 3'd3,
    ST_SPIN  = 3'd4,
    ST_DRAIN = 3'd5,
    ST_DONE  = 3'd6,
    ST_FAULT = 3'd7
  } state_t;

  // Credit increment that holds at CREDIT_MAX.
  function automatic logic [CREDIT_W-1:0] credit_sat_inc(input logic [CREDIT_W-1:0] c);
    return (c == CREDIT_W'(CREDIT_MAX)) ? c : c + CREDIT_W'(1);
  endfunction

endpackage

// File: rtl/panel_input_conditioner_debouncer.sv
// Two-flop synchronizer followed by a stability counter.
// Ports:
//   clock   - rising-edge clock
//   reset_n - asynchronous active-low reset
//   raw     - asynchronous, possibly bouncing input
//   level   - debounced level (registered)
module panel_input_conditioner_debouncer
  import panel_input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw,
  output logic level
);

  logic                 sync0_q;
  logic                 sync1_q;
  logic [DEB_CNT_W-1:0] cnt_q;
  logic [DEB_CNT_W-1:0] cnt_d;
  logic                 level_q;
  logic                 level_d;

  // Metastability guard.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
    end else begin
      sync0_q <= raw;
      sync1_q <= sync0_q;
    end
  end

  // Count cycles of disagreement; the count is compared before the
  // increment so a level held from edge k lands at edge k+2+DEBOUNCE_CYCLES.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync1_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == DEB_CNT_W'(DEBOUNCE_CYCLES)) begin
      level_d = sync1_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + DEB_CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/panel_input_conditioner.sv
// Conditions the lid, coin and cancel panel inputs: debounces them, keeps
// the coin credit, and issues cancel / refund pulses.
// Ports:
//   clock, reset_n  - rising-edge clock, asynchronous active-low reset
//   raw_Lid/Coin/Cancel - raw asynchronous switch inputs
//   state           - current controller state (state_t encoding)
//   sig_Lid_Closed  - debounced lid level
//   sig_Coin        - high while credit covers the price
//   sig_Cancel      - one-cycle pulse per debounced cancel press
//   coin_Refund     - one-cycle pulse when credit is returned
//   refund_Count    - coins returned while coin_Refund is high, else 0
//   credit          - current coin credit
// sig_Cancel, coin_Refund, refund_Count and sig_Coin are decoded from
// registered state in the same cycle as the event they report.
module panel_input_conditioner
  import panel_input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned COIN_PRICE      = COIN_PRICE_DEFAULT
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                raw_Lid,
  input  logic                raw_Coin,
  input  logic                raw_Cancel,
  input  logic [STATE_W-1:0]  state,
  output logic                sig_Lid_Closed,
  output logic                sig_Coin,
  output logic                sig_Cancel,
  output logic                coin_Refund,
  output logic [CREDIT_W-1:0] refund_Count,
  output logic [CREDIT_W-1:0] credit
);

  localparam logic [STATE_W-1:0]  IDLE_CODE = ST_IDLE;
  localparam logic [CREDIT_W-1:0] PRICE     = CREDIT_W'(COIN_PRICE);

  logic                deb_lid;
  logic                deb_coin;
  logic                deb_cancel;
  logic                coin_q;
  logic                cancel_q;
  logic [STATE_W-1:0]  prev_state_q;
  logic [CREDIT_W-1:0] credit_q;
  logic [CREDIT_W-1:0] credit_d;
  logic [CREDIT_W-1:0] credit_inc_c;
  logic                coin_rise_c;
  logic                cancel_rise_c;
  logic                in_idle_c;
  logic                idle_exit_c;
  logic                refund_c;

  panel_input_conditioner_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_lid (
    .clock   (clock),
    .reset_n (reset_n),
    .raw     (raw_Lid),
    .level   (deb_lid)
  );

  panel_input_conditioner_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_coin (
    .clock   (clock),
    .reset_n (reset_n),
    .raw     (raw_Coin),
    .level   (deb_coin)
  );

  panel_input_conditioner_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_cancel (
    .clock   (clock),
    .reset_n (reset_n),
    .raw     (raw_Cancel),
    .level   (deb_cancel)
  );

  // Edge detection, credit arithmetic and refund decision.
  always_comb begin
    coin_rise_c   = deb_coin & ~coin_q;
    cancel_rise_c = deb_cancel & ~cancel_q;
    in_idle_c     = (state == IDLE_CODE);
    idle_exit_c   = (prev_state_q == IDLE_CODE) && !in_idle_c;
    credit_inc_c  = coin_rise_c ? credit_sat_inc(credit_q) : credit_q;
    refund_c      = cancel_rise_c && in_idle_c && (credit_inc_c != '0);
    credit_d      = credit_inc_c;
    if (refund_c) begin
      credit_d = '0;
    end else if (idle_exit_c && (credit_inc_c >= PRICE)) begin
      credit_d = credit_inc_c - PRICE;
    end
  end

  // Edge-detect history, previous controller state and credit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      coin_q       <= 1'b0;
      cancel_q     <= 1'b0;
      prev_state_q <= IDLE_CODE;
      credit_q     <= '0;
    end else begin
      coin_q       <= deb_coin;
      cancel_q     <= deb_cancel;
      prev_state_q <= state;
      credit_q     <= credit_d;
    end
  end

  assign sig_Lid_Closed = deb_lid;
  assign sig_Coin       = (credit_q >= PRICE);
  assign sig_Cancel     = cancel_rise_c;
  assign coin_Refund    = refund_c;
  assign refund_Count   = refund_c ? credit_inc_c : '0;
  assign credit         = credit_q;

endmodule

// File: tb/tb_panel_input_conditioner.sv
// Scoreboard bench for panel_input_conditioner: expected output events are
// queued as stimulus is driven and consumed when the monitor sees them.
module tb_panel_input_conditioner;

  localparam int unsigned DEB   = 4;
  localparam int unsigned PRICE = 3;

  logic       clock;
  logic       reset_n;
  logic       raw_Lid;
  logic       raw_Coin;
  logic       raw_Cancel;
  logic [2:0] state;
  logic       sig_Lid_Closed;
  logic       sig_Coin;
  logic       sig_Cancel;
  logic       coin_Refund;
  logic [3:0] refund_Count;
  logic [3:0] credit;

  typedef struct packed {
    logic       cancel;
    logic       refund;
    logic [3:0] count;
    logic [3:0] credit;
    logic       coin;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        ev;
  int         n_checks;
  int         n_errors;
  logic       mon_en;
  logic [3:0] last_credit;
  int         model_credit;

  panel_input_conditioner #(.DEBOUNCE_CYCLES(DEB), .COIN_PRICE(PRICE)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .raw_Lid        (raw_Lid),
    .raw_Coin       (raw_Coin),
    .raw_Cancel     (raw_Cancel),
    .state          (state),
    .sig_Lid_Closed (sig_Lid_Closed),
    .sig_Coin       (sig_Coin),
    .sig_Cancel     (sig_Cancel),
    .coin_Refund    (coin_Refund),
    .refund_Count   (refund_Count),
    .credit         (credit)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void expect_ev(input logic c, input logic r, input logic [3:0] n,
                                    input logic [3:0] cr);
    ev_t e;
    e.cancel = c;
    e.refund = r;
    e.count  = n;
    e.credit = cr;
    e.coin   = (cr >= 4'(PRICE));
    exp_q.push_back(e);
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic coin_press();
    if (model_credit < 15) begin
      model_credit++;
      expect_ev(1'b0, 1'b0, 4'd0, 4'(model_credit));
    end
    raw_Coin = 1'b1;
    cycles(10);
    raw_Coin = 1'b0;
    cycles(10);
  endtask

  task automatic cancel_press();
    raw_Cancel = 1'b1;
    cycles(10);
    raw_Cancel = 1'b0;
    cycles(10);
  endtask

  // Monitor: any cancel pulse or credit change is an event to be matched.
  always @(negedge clock) begin
    if (mon_en && (sig_Cancel || (credit != last_credit))) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_event", 32'(exp_q.size()), 32'd1);
      end else begin
        ev = exp_q.pop_front();
        check("ev_sig_Cancel", 32'(sig_Cancel), 32'(ev.cancel));
        check("ev_coin_Refund", 32'(coin_Refund), 32'(ev.refund));
        check("ev_refund_Count", 32'(refund_Count), 32'(ev.count));
        check("ev_credit", 32'(credit), 32'(ev.credit));
        check("ev_sig_Coin", 32'(sig_Coin), 32'(ev.coin));
      end
    end
    last_credit = credit;
  end

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    mon_en       = 1'b0;
    last_credit  = 4'd0;
    model_credit = 0;
    reset_n      = 1'b0;
    raw_Lid      = 1'b0;
    raw_Coin     = 1'b0;
    raw_Cancel   = 1'b0;
    state        = 3'd0;

    // Outputs held at zero in reset.
    cycles(3);
    check("rst_lid", 32'(sig_Lid_Closed), 32'd0);
    check("rst_coin", 32'(sig_Coin), 32'd0);
    check("rst_cancel", 32'(sig_Cancel), 32'd0);
    check("rst_refund", 32'(coin_Refund), 32'd0);
    check("rst_count", 32'(refund_Count), 32'd0);
    check("rst_credit", 32'(credit), 32'd0);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    cycles(2);

    // Lid latency: sampled at edge k, visible after edge k+2+DEB.
    raw_Lid = 1'b1;
    cycles(DEB + 2);
    check("lid_before_latency", 32'(sig_Lid_Closed), 32'd0);
    cycles(1);
    check("lid_at_latency", 32'(sig_Lid_Closed), 32'd1);
    // Short low glitch must not propagate.
    raw_Lid = 1'b0;
    cycles(3);
    raw_Lid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycles(1);
      check("lid_glitch_hold", 32'(sig_Lid_Closed), 32'd1);
    end

    // Three coins, then leave idle to pay.
    coin_press();
    coin_press();
    coin_press();
    model_credit -= int'(PRICE);
    expect_ev(1'b0, 1'b0, 4'd0, 4'(model_credit));
    state = 3'd2;
    cycles(3);
    state = 3'd0;
    cycles(3);

    // Two coins then cancel held long: single pulse with refund of 2.
    coin_press();
    coin_press();
    expect_ev(1'b1, 1'b1, 4'(model_credit), 4'(model_credit));
    expect_ev(1'b0, 1'b0, 4'd0, 4'd0);
    model_credit = 0;
    cancel_press();
    // Re-press with zero credit: pulse only.
    expect_ev(1'b1, 1'b0, 4'd0, 4'd0);
    cancel_press();

    // Cancel outside idle: pulse only, credit kept.
    coin_press();
    state = 3'd4;
    cycles(3);
    expect_ev(1'b1, 1'b0, 4'd0, 4'(model_credit));
    cancel_press();
    state = 3'd0;
    cycles(3);

    // Saturation, then refund the full 15.
    for (int i = 0; i < 16; i++) coin_press();
    check("credit_saturated", 32'(credit), 32'd15);
    expect_ev(1'b1, 1'b1, 4'd15, 4'd15);
    expect_ev(1'b0, 1'b0, 4'd0, 4'd0);
    model_credit = 0;
    cancel_press();

    // Coin and cancel debounced together at credit 2: refund 3.
    coin_press();
    coin_press();
    expect_ev(1'b1, 1'b1, 4'd3, 4'd2);
    expect_ev(1'b0, 1'b0, 4'd0, 4'd0);
    model_credit = 0;
    raw_Coin   = 1'b1;
    raw_Cancel = 1'b1;
    cycles(10);
    raw_Coin   = 1'b0;
    raw_Cancel = 1'b0;
    cycles(10);

    // Coin edge in the same cycle as leaving idle: 2 + 1 - 3 = 0.
    coin_press();
    coin_press();
    expect_ev(1'b0, 1'b0, 4'd0, 4'd0);
    model_credit = 0;
    raw_Coin = 1'b1;
    cycles(DEB + 3);
    state = 3'd1;
    cycles(3);
    raw_Coin = 1'b0;
    cycles(10);
    state = 3'd0;
    cycles(3);

    // Reset with credit and a debounce in progress.
    coin_press();
    coin_press();
    raw_Coin = 1'b1;
    cycles(4);
    mon_en = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_lid", 32'(sig_Lid_Closed), 32'd0);
    check("midrst_coin", 32'(sig_Coin), 32'd0);
    check("midrst_cancel", 32'(sig_Cancel), 32'd0);
    check("midrst_refund", 32'(coin_Refund), 32'd0);
    check("midrst_count", 32'(refund_Count), 32'd0);
    check("midrst_credit", 32'(credit), 32'd0);
    raw_Coin = 1'b0;
    cycles(2);
    reset_n = 1'b1;
    model_credit = 0;
    cycles(1);
    mon_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycles(1);
      check("post_rst_refund", 32'(coin_Refund), 32'd0);
    end
    check("post_rst_credit", 32'(credit), 32'd0);

    cycles(5);
    check("sb_pending_events", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
